// File: rtl/iir_filter_2nd_order_pkg.sv
// Shared sizing constants and the operating-mode encoding for the biquad IIR filter family.
// Included by the top and by the reusable clamp stage.
package iir_filter_2nd_order_pkg;

  localparam int COEF_SIZE_DEFAULT = 35;
  localparam int INT_SIZE          = 35;
  localparam int PROD_SIZE         = 70;
  localparam int X_ALIGN           = 32;

  typedef enum logic [1:0] {
    MODE_RUN,
    MODE_HOLD,
    MODE_OFF
  } mode_t;

endpackage

// File: rtl/iir_filter_2nd_order_saturate.sv
// Combinational clamp of a recursion value to [lower, upper]; upper wins when the limits cross.
// Reused by cascaded/higher-order filter stages.
module iir_saturate
  import iir_filter_2nd_order_pkg::*;
(
  input  logic signed [INT_SIZE-1:0] value,
  input  logic signed [INT_SIZE-1:0] upper,
  input  logic signed [INT_SIZE-1:0] lower,
  output logic signed [INT_SIZE-1:0] result,
  output logic                       railed
);

  logic signed [INT_SIZE-1:0] floored;

  // Floor first, then ceiling, so crossed limits resolve to upper.
  always_comb begin
    floored = (value < lower) ? lower : value;
    result  = (floored > upper) ? upper : floored;
    railed  = (result != value);
  end

endmodule

// File: rtl/iir_filter_2nd_order.sv
// Second-order (biquad) IIR filter, one sample per clock, with atomic coefficient bank and hold.
// Define IIR_ANTIWINDUP_EN to clamp the stored recursion state to [y_min_in, y_max_in].
module iir_filter_2nd_order
  import iir_filter_2nd_order_pkg::*;
#(
  parameter int SIGNAL_IN_SIZE  = 16,
  parameter int SIGNAL_OUT_SIZE = 16,
  parameter int A0_SHIFT        = 26,
  parameter int COEF_SIZE       = COEF_SIZE_DEFAULT
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              on_in,
  input  logic                              hold_in,
  input  logic                              coef_load_in,
  input  logic signed [COEF_SIZE-1:0]       a1_in,
  input  logic signed [COEF_SIZE-1:0]       a2_in,
  input  logic signed [COEF_SIZE-1:0]       b0_in,
  input  logic signed [COEF_SIZE-1:0]       b1_in,
  input  logic signed [COEF_SIZE-1:0]       b2_in,
  input  logic signed [SIGNAL_OUT_SIZE-1:0] y_max_in,
  input  logic signed [SIGNAL_OUT_SIZE-1:0] y_min_in,
  input  logic signed [SIGNAL_IN_SIZE-1:0]  signal_in,
  output logic signed [SIGNAL_OUT_SIZE-1:0] signal_out,
  output logic                              railed_out
);

  localparam int IN_ALIGN  = X_ALIGN - SIGNAL_IN_SIZE;
  localparam int OUT_ALIGN = X_ALIGN - SIGNAL_OUT_SIZE;

  logic signed [COEF_SIZE-1:0]       a1_reg, a2_reg, b0_reg, b1_reg, b2_reg;
  logic signed [PROD_SIZE-1:0]       p0_reg, p1_reg, p2_reg;
  logic signed [INT_SIZE-1:0]        y_reg, y2_reg;
  logic signed [SIGNAL_OUT_SIZE-1:0] out_reg;
  logic                              railed_reg;

  logic signed [X_ALIGN-1:0]   x32;
  logic signed [PROD_SIZE-1:0] x_ext;
  logic signed [PROD_SIZE-1:0] fb_sum;
  logic signed [INT_SIZE-1:0]  y_raw;
  logic signed [INT_SIZE-1:0]  y_hi, y_lo;
  logic signed [INT_SIZE-1:0]  y_next;
  logic                        sat_railed;
  logic                        railed_next;
  mode_t                       mode;

  assign x32    = X_ALIGN'(signal_in) <<< IN_ALIGN;
  assign x_ext  = PROD_SIZE'(x32);
  assign fb_sum = PROD_SIZE'(a1_reg) * PROD_SIZE'(y_reg)
                + PROD_SIZE'(a2_reg) * PROD_SIZE'(y2_reg)
                + p0_reg;
  assign y_raw  = INT_SIZE'(fb_sum >>> A0_SHIFT);

`ifdef IIR_ANTIWINDUP_EN
  assign y_hi        = INT_SIZE'(X_ALIGN'(y_max_in) <<< OUT_ALIGN);
  assign y_lo        = INT_SIZE'(X_ALIGN'(y_min_in) <<< OUT_ALIGN);
  assign railed_next = sat_railed;
`else
  // Full-range limits make the clamp an identity; the flag is forced low.
  logic unused_limits;
  assign unused_limits = ^{y_max_in, y_min_in, sat_railed};
  assign y_hi          = {1'b0, {(INT_SIZE-1){1'b1}}};
  assign y_lo          = {1'b1, {(INT_SIZE-1){1'b0}}};
  assign railed_next   = 1'b0;
`endif

  iir_saturate u_saturate (
    .value  (y_raw),
    .upper  (y_hi),
    .lower  (y_lo),
    .result (y_next),
    .railed (sat_railed)
  );

  always_comb begin
    mode = MODE_RUN;
    if (!on_in) begin
      mode = MODE_OFF;
    end else if (hold_in) begin
      mode = MODE_HOLD;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      a1_reg     <= '0;
      a2_reg     <= '0;
      b0_reg     <= '0;
      b1_reg     <= '0;
      b2_reg     <= '0;
      p0_reg     <= '0;
      p1_reg     <= '0;
      p2_reg     <= '0;
      y_reg      <= '0;
      y2_reg     <= '0;
      out_reg    <= '0;
      railed_reg <= 1'b0;
    end else begin
      if (coef_load_in) begin
        a1_reg <= a1_in;
        a2_reg <= a2_in;
        b0_reg <= b0_in;
        b1_reg <= b1_in;
        b2_reg <= b2_in;
      end
      case (mode)
        MODE_OFF: begin
          p0_reg     <= '0;
          p1_reg     <= '0;
          p2_reg     <= '0;
          y_reg      <= '0;
          y2_reg     <= '0;
          out_reg    <= x32[X_ALIGN-1:OUT_ALIGN];
          railed_reg <= 1'b0;
        end
        MODE_RUN: begin
          // Transposed FIR chain feeds p0 into the recursion one edge later.
          p2_reg     <= PROD_SIZE'(b2_reg) * x_ext;
          p1_reg     <= PROD_SIZE'(b1_reg) * x_ext + p2_reg;
          p0_reg     <= PROD_SIZE'(b0_reg) * x_ext + p1_reg;
          y_reg      <= y_next;
          y2_reg     <= y_reg;
          out_reg    <= y_reg[X_ALIGN-1:OUT_ALIGN];
          railed_reg <= railed_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign signal_out = out_reg;
  assign railed_out = railed_reg;

endmodule
